matrix_port_arbiter: RTL and testbench

- Owns a ROWS x COLS array of WIDTH-bit cells (row/col addressed, same organisation as the team's multi-dimensional byte matrix).
- Shares the array between two requesters, A and B, using round-robin arbitration with one access per cycle.
- Embeds a hardware clear sequencer that zeroes every cell in row-major order.
- Sits between two independent masters (e.g. a host write path and a scan/readout engine) and the matrix storage.

---
 rtl/matrix_ctrl_pkg.sv | 19 +
 rtl/matrix_rr_arb.sv | 44 ++++
 rtl/matrix_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_matrix_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_ctrl_pkg.sv
// Shared types for the matrix port arbiter: controller states, requester ids
// and the address-width helper used to size row/column ports.
package matrix_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_rr_arb.sv
// Two-way round-robin arbiter; the priority pointer moves to the other
// requester after every grant and holds on idle cycles.
module matrix_rr_arb
  import matrix_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       enable_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  req_id_e prio_q, prio_d;

  always_comb begin
    gnt_o = '0;
    if (enable_i) begin
      if (req_i[REQ_A] && (!req_i[REQ_B] || prio_q == REQ_A)) begin
        gnt_o[REQ_A] = 1'b1;
      end else if (req_i[REQ_B]) begin
        gnt_o[REQ_B] = 1'b1;
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (advance_i && gnt_o[REQ_A]) begin
      prio_d = REQ_B;
    end else if (advance_i && gnt_o[REQ_B]) begin
      prio_d = REQ_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= REQ_A;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/matrix_port_arbiter.sv
// ROWS x COLS cell matrix shared by two requesters through a round-robin
// arbiter, with a row-major clear sequencer that locks out both requesters.
module matrix_port_arbiter
  import matrix_ctrl_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned ROWS  = 4,
  parameter  int unsigned COLS  = 4,
  localparam int unsigned RW    = addr_w(ROWS),
  localparam int unsigned CW    = addr_w(COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [RW-1:0]    a_row,
  input  logic [CW-1:0]    a_col,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [RW-1:0]    b_row,
  input  logic [CW-1:0]    b_col,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] b_rdata,
  input  logic             clear_start,
  output logic             clear_busy,
  output logic             clear_done
);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW:0]   ROWS_L   = (RW + 1)'(ROWS);
  localparam logic [CW:0]   COLS_L   = (CW + 1)'(COLS);

  logic [WIDTH-1:0] mem_q [ROWS][COLS];

  state_e           state_q, state_d;
  logic [RW-1:0]    clr_row_q, clr_row_d;
  logic [CW-1:0]    clr_col_q, clr_col_d;
  logic             done_q, done_d;
  logic             a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic [1:0]       gnt;
  logic             arb_en;
  logic             a_hit, b_hit;
  logic             wr_en;
  logic [RW-1:0]    wr_row;
  logic [CW-1:0]    wr_col;
  logic [WIDTH-1:0] wr_data;

  // Grants are qualified by rst_n so they fall with the reset edge itself.
  assign arb_en = rst_n && (state_q == IDLE);

  matrix_rr_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({b_req, a_req}),
    .enable_i (arb_en),
    .advance_i(arb_en),
    .gnt_o    (gnt)
  );

  assign a_gnt      = gnt[REQ_A];
  assign b_gnt      = gnt[REQ_B];
  assign a_hit      = ({1'b0, a_row} < ROWS_L) && ({1'b0, a_col} < COLS_L);
  assign b_hit      = ({1'b0, b_row} < ROWS_L) && ({1'b0, b_col} < COLS_L);
  assign clear_busy = (state_q == CLEAR);
  assign clear_done = done_q;
  assign a_rvalid   = a_rvalid_q;
  assign a_rdata    = a_rdata_q;
  assign b_rvalid   = b_rvalid_q;
  assign b_rdata    = b_rdata_q;

  always_comb begin
    state_d   = state_q;
    clr_row_d = clr_row_q;
    clr_col_d = clr_col_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d   = CLEAR;
          clr_row_d = '0;
          clr_col_d = '0;
        end
      end
      CLEAR: begin
        if (clr_col_q == LAST_COL) begin
          clr_col_d = '0;
          clr_row_d = clr_row_q + 1'b1;
        end else begin
          clr_col_d = clr_col_q + 1'b1;
        end
        if (clr_row_q == LAST_ROW && clr_col_q == LAST_COL) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_rvalid_d = a_gnt && !a_we;
    b_rvalid_d = b_gnt && !b_we;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    if (a_rvalid_d) a_rdata_d = a_hit ? mem_q[a_row][a_col] : '0;
    if (b_rvalid_d) b_rdata_d = b_hit ? mem_q[b_row][b_col] : '0;
  end

  // Single write port: the sweep owns it in CLEAR, otherwise the granted writer.
  always_comb begin
    wr_en   = 1'b0;
    wr_row  = clr_row_q;
    wr_col  = clr_col_q;
    wr_data = '0;
    if (state_q == CLEAR) begin
      wr_en = 1'b1;
    end else if (a_gnt && a_we && a_hit) begin
      wr_en   = 1'b1;
      wr_row  = a_row;
      wr_col  = a_col;
      wr_data = a_wdata;
    end else if (b_gnt && b_we && b_hit) begin
      wr_en   = 1'b1;
      wr_row  = b_row;
      wr_col  = b_col;
      wr_data = b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_row][wr_col] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_row_q  <= '0;
      clr_col_q  <= '0;
      done_q     <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_row_q  <= clr_row_d;
      clr_col_q  <= clr_col_d;
      done_q     <= done_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

endmodule

// File: tb/tb_matrix_port_arbiter.sv
// Self-checking bench: a cell-array model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_matrix_port_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned RW    = 2;
  localparam int unsigned CW    = 2;
  localparam int          CELLS = ROWS * COLS;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a_req, a_we, b_req, b_we, clear_start;
  logic [RW-1:0]    a_row, b_row;
  logic [CW-1:0]    a_col, b_col;
  logic [WIDTH-1:0] a_wdata, b_wdata;
  logic             a_gnt, a_rvalid, b_gnt, b_rvalid, clear_busy, clear_done;
  logic [WIDTH-1:0] a_rdata, b_rdata;

  always #5 clk = ~clk;

  matrix_port_arbiter #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_row(a_row), .a_col(a_col), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_row(b_row), .b_col(b_col), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got no grant expected grant within budget (t=%0t)", nm, $time);
  endtask

  // Model: cell values with a known flag, priority owner, cells left to clear.
  logic [WIDTH-1:0] m_mem   [ROWS][COLS];
  bit               m_known [ROWS][COLS];
  bit               m_prio_b;
  int               m_clear_left;
  bit               m_done;
  bit               m_arv, m_brv, m_ard_k, m_brd_k;
  logic [WIDTH-1:0] m_ard, m_brd;
  bit               a_g_seen, b_g_seen;
  int               done_pulses = 0;

  initial begin
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_known[r][c] = 1'b0;
  end

  always @(negedge clk) begin : compare
    bit ega, egb;
    int idx;
    if (!rst_n) begin
      chk("rst_a_gnt", a_gnt, 0);
      chk("rst_b_gnt", b_gnt, 0);
      chk("rst_a_rvalid", a_rvalid, 0);
      chk("rst_b_rvalid", b_rvalid, 0);
      chk("rst_a_rdata", a_rdata, 0);
      chk("rst_b_rdata", b_rdata, 0);
      chk("rst_busy", clear_busy, 0);
      chk("rst_done", clear_done, 0);
      if (m_clear_left > 0)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) m_known[r][c] = 1'b0;
      m_prio_b = 0; m_clear_left = 0; m_done = 0;
      m_arv = 0; m_brv = 0; m_ard = '0; m_brd = '0; m_ard_k = 1; m_brd_k = 1;
      a_g_seen = 0; b_g_seen = 0;
    end else begin
      ega = 0; egb = 0;
      if (m_clear_left == 0) begin
        if (a_req && (!b_req || !m_prio_b)) ega = 1;
        else if (b_req) egb = 1;
      end
      chk("a_gnt", a_gnt, ega);
      chk("b_gnt", b_gnt, egb);
      chk("a_rvalid", a_rvalid, m_arv);
      chk("b_rvalid", b_rvalid, m_brv);
      if (m_ard_k) chk("a_rdata", a_rdata, m_ard);
      if (m_brd_k) chk("b_rdata", b_rdata, m_brd);
      chk("clear_busy", clear_busy, m_clear_left > 0);
      chk("clear_done", clear_done, m_done);
      a_g_seen = a_gnt;
      b_g_seen = b_gnt;
      if (clear_done) done_pulses++;

      m_done = (m_clear_left == 1);
      if (m_clear_left > 0) begin
        idx = CELLS - m_clear_left;
        m_mem[idx / COLS][idx % COLS]   = '0;
        m_known[idx / COLS][idx % COLS] = 1'b1;
        m_clear_left--;
      end else if (clear_start) begin
        m_clear_left = CELLS;
      end
      m_arv = ega && !a_we;
      m_brv = egb && !b_we;
      if (m_arv) begin
        m_ard   = m_mem[a_row][a_col];
        m_ard_k = m_known[a_row][a_col];
      end
      if (m_brv) begin
        m_brd   = m_mem[b_row][b_col];
        m_brd_k = m_known[b_row][b_col];
      end
      if (ega && a_we) begin m_mem[a_row][a_col] = a_wdata; m_known[a_row][a_col] = 1'b1; end
      if (egb && b_we) begin m_mem[b_row][b_col] = b_wdata; m_known[b_row][b_col] = 1'b1; end
      if (ega) m_prio_b = 1;
      else if (egb) m_prio_b = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_access(input bit we, input int r, input int c, input logic [WIDTH-1:0] d);
    a_req = 1; a_we = we; a_row = r[RW-1:0]; a_col = c[CW-1:0]; a_wdata = d;
    for (int i = 0; i < 64; i++) begin
      step();
      if (a_g_seen) begin a_req = 0; return; end
    end
    a_req = 0;
    timeout("a_access");
  endtask

  task automatic b_access(input bit we, input int r, input int c, input logic [WIDTH-1:0] d);
    b_req = 1; b_we = we; b_row = r[RW-1:0]; b_col = c[CW-1:0]; b_wdata = d;
    for (int i = 0; i < 64; i++) begin
      step();
      if (b_g_seen) begin b_req = 0; return; end
    end
    b_req = 0;
    timeout("b_access");
  endtask

  // Cycle 1 is the first busy cycle; a second start can be injected at extra_at.
  task automatic run_clear(input string nm, input int extra_at);
    int busy_cnt, done_at, p0;
    clear_start = 1;
    step();
    clear_start = 0;
    busy_cnt = 0; done_at = 0; p0 = done_pulses;
    for (int i = 1; i <= 30; i++) begin
      if (clear_busy) busy_cnt++;
      if (clear_done && done_at == 0) done_at = i;
      clear_start = (i == extra_at);
      step();
    end
    chk({nm, "_busy_cycles"}, busy_cnt, CELLS);
    chk({nm, "_done_cycle"}, done_at, CELLS + 1);
    chk({nm, "_done_pulses"}, done_pulses - p0, 1);
  endtask

  initial begin : stim
    int k;
    rst_n = 0; clear_start = 0;
    a_req = 0; a_we = 0; a_row = '0; a_col = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_row = '0; b_col = '0; b_wdata = '0;
    repeat (3) step();
    rst_n = 1;
    step();

    run_clear("clear1", 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        a_access(0, r, c, '0);
        chk("cleared_rvalid", a_rvalid, 1);
        chk("cleared_rdata", a_rdata, 8'h00);
      end

    a_access(1, 2, 1, 8'h5A);
    a_access(0, 2, 1, '0);
    chk("wr_rd_rvalid", a_rvalid, 1);
    chk("wr_rd_rdata", a_rdata, 8'h5A);
    chk("wr_rd_b_rvalid", b_rvalid, 0);

    b_access(0, 0, 0, '0);
    a_req = 1; a_we = 0; b_req = 1; b_we = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("alt_a_gnt", a_g_seen, (i % 2) == 0);
      chk("alt_b_gnt", b_g_seen, (i % 2) == 1);
    end
    a_req = 0;
    step();
    chk("b_alone_gnt", b_g_seen, 1);
    b_req = 0;

    b_access(1, 3, 3, 8'hC3);
    b_req = 1; b_we = 0; b_row = 2'd3; b_col = 2'd3; clear_start = 1;
    step();
    clear_start = 0; b_req = 0;
    chk("start_b_gnt", b_g_seen, 1);
    chk("start_b_rvalid", b_rvalid, 1);
    chk("start_b_rdata", b_rdata, 8'hC3);
    step();
    a_req = 1; a_we = 0; a_row = '0; a_col = '0;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      k++;
      if (a_g_seen) break;
    end
    if (!a_g_seen) timeout("stall_grant");
    chk("stall_cycles", k, CELLS);
    a_req = 0;
    step();

    clear_start = 1;
    step();
    clear_start = 0;
    repeat (6) step();
    a_req = 1; b_req = 1; a_we = 0; b_we = 0;
    chk("busy_before_rst", clear_busy, 1);
    rst_n = 0;
    #1;
    chk("async_busy", clear_busy, 0);
    chk("async_a_gnt", a_gnt, 0);
    chk("async_b_gnt", b_gnt, 0);
    chk("async_a_rvalid", a_rvalid, 0);
    chk("async_done", clear_done, 0);
    step();
    step();
    rst_n = 1;
    step();
    chk("post_rst_a_gnt", a_g_seen, 1);
    chk("post_rst_b_gnt", b_g_seen, 0);
    a_req = 0; b_req = 0;
    step();
    run_clear("clear2", 0);
    run_clear("clear3", 5);

    for (int n = 0; n < 3000; n++) begin
      if (!a_req || a_g_seen) begin
        a_req = ($urandom_range(0, 2) != 0); a_we = $urandom_range(0, 1);
        a_row = RW'($urandom_range(0, ROWS - 1)); a_col = CW'($urandom_range(0, COLS - 1));
        a_wdata = WIDTH'($urandom);
      end
      if (!b_req || b_g_seen) begin
        b_req = ($urandom_range(0, 2) != 0); b_we = $urandom_range(0, 1);
        b_row = RW'($urandom_range(0, ROWS - 1)); b_col = CW'($urandom_range(0, COLS - 1));
        b_wdata = WIDTH'($urandom);
      end
      clear_start = ($urandom_range(0, 99) == 0) && !clear_start;
      step();
    end
    a_req = 0; b_req = 0; clear_start = 0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
